// File: rtl/game_state_fsm.sv
// Game flow sequencer: TITLE -> PLAYING <-> PAUSED -> DYING -> GAME_OVER -> PLAYING.
// Derives the frame tick from VGA_VS and keeps the survival timer, level and best time.
module game_state_fsm #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int LEVEL_SECS     = 10,
    parameter int DYING_FRAMES   = 90,
    parameter int LOCK_FRAMES    = 30
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       VGA_VS,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       collision,
    output logic [2:0] State,
    output logic       frame_tick,
    output logic [9:0] seconds,
    output logic [2:0] level,
    output logic [9:0] best_seconds,
    output logic       new_record
);

    localparam int FW   = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int LW   = (LEVEL_SECS > 1) ? $clog2(LEVEL_SECS) : 1;
    localparam int DMAX = (DYING_FRAMES > LOCK_FRAMES) ? DYING_FRAMES : LOCK_FRAMES;
    localparam int DW   = $clog2(DMAX + 1);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_PLAYING   = 3'd1,
        S_DYING     = 3'd2,
        S_GAME_OVER = 3'd3,
        S_PAUSED    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            vs_q, start_q, pause_q;
    logic            tick_q, tick_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LW-1:0]   level_cnt_q, level_cnt_d;
    logic [9:0]      seconds_q, seconds_d;
    logic [2:0]      level_q, level_d;
    logic [9:0]      best_q, best_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            new_record_q, new_record_d;
    logic            start_edge, pause_edge;

    assign start_edge = key_start & ~start_q;
    assign pause_edge = key_pause & ~pause_q;

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q      <= S_TITLE;
            vs_q         <= 1'b0;
            // Keys held through reset must not look like a fresh press afterwards.
            start_q      <= key_start;
            pause_q      <= key_pause;
            tick_q       <= 1'b0;
            frame_cnt_q  <= '0;
            level_cnt_q  <= '0;
            seconds_q    <= '0;
            level_q      <= '0;
            best_q       <= '0;
            dwell_q      <= '0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= VGA_VS;
            start_q      <= key_start;
            pause_q      <= key_pause;
            tick_q       <= tick_d;
            frame_cnt_q  <= frame_cnt_d;
            level_cnt_q  <= level_cnt_d;
            seconds_q    <= seconds_d;
            level_q      <= level_d;
            best_q       <= best_d;
            dwell_q      <= dwell_d;
            new_record_q <= new_record_d;
        end
    end

    always_comb begin
        tick_d       = vs_q & ~VGA_VS;
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        level_cnt_d  = level_cnt_q;
        seconds_d    = seconds_q;
        level_d      = level_q;
        best_d       = best_q;
        dwell_d      = dwell_q;
        new_record_d = new_record_q;

        case (state_q)
            S_TITLE: begin
                if (start_edge) begin
                    state_d     = S_PLAYING;
                    frame_cnt_d = '0;
                    level_cnt_d = '0;
                    seconds_d   = '0;
                    level_d     = '0;
                end
            end
            S_PLAYING: begin
                // Collision wins over pause and swallows a coincident tick.
                if (collision) begin
                    state_d = S_DYING;
                    dwell_d = '0;
                    if (seconds_q > best_q) begin
                        best_d       = seconds_q;
                        new_record_d = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                    end
                end else if (pause_edge) begin
                    state_d = S_PAUSED;
                end else if (tick_q) begin
                    if (frame_cnt_q == FW'(FRAMES_PER_SEC - 1)) begin
                        frame_cnt_d = '0;
                        if (seconds_q != 10'd999) seconds_d = seconds_q + 10'd1;
                        if (level_cnt_q == LW'(LEVEL_SECS - 1)) begin
                            level_cnt_d = '0;
                            if (level_q != 3'd7) level_d = level_q + 3'd1;
                        end else begin
                            level_cnt_d = level_cnt_q + LW'(1);
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            S_PAUSED: begin
                if (pause_edge) state_d = S_PLAYING;
            end
            S_DYING: begin
                if (tick_q) begin
                    if (dwell_q == DW'(DYING_FRAMES - 1)) begin
                        state_d = S_GAME_OVER;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            S_GAME_OVER: begin
                // dwell_q saturates at LOCK_FRAMES and then unlocks the start key.
                if (start_edge && dwell_q >= DW'(LOCK_FRAMES)) begin
                    state_d      = S_PLAYING;
                    frame_cnt_d  = '0;
                    level_cnt_d  = '0;
                    seconds_d    = '0;
                    level_d      = '0;
                    new_record_d = 1'b0;
                end else if (tick_q && dwell_q < DW'(LOCK_FRAMES)) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    assign State        = state_q;
    assign frame_tick   = tick_q;
    assign seconds      = seconds_q;
    assign level        = level_q;
    assign best_seconds = best_q;
    assign new_record   = new_record_q;

endmodule
